// File: rtl/color_sequencer_if.sv
// ---------------------------------------------------------------------------
// color_sequencer_if
// Board-side and processor-side signals of the colour sequencer.
//   btn_h, btn_v, btn_pal : raw asynchronous pushbuttons (to sequencer)
//   auto_en               : synchronous auto-demo enable (to sequencer)
//   swap_h, swap_v        : swap strobes to the colour processor
//   color_valid           : one-cycle palette load strobe
//   rgb0..rgb3            : palette colours, 24 bit each
//   palette_idx           : currently selected palette
//   busy                  : sequencer is performing an operation
// modport master : the sequencer itself
// modport slave  : the board / processor side
// ---------------------------------------------------------------------------
interface color_sequencer_if;
  logic        btn_h;
  logic        btn_v;
  logic        btn_pal;
  logic        auto_en;
  logic        swap_h;
  logic        swap_v;
  logic        color_valid;
  logic [23:0] rgb0;
  logic [23:0] rgb1;
  logic [23:0] rgb2;
  logic [23:0] rgb3;
  logic [1:0]  palette_idx;
  logic        busy;

  modport master (
    input  btn_h, btn_v, btn_pal, auto_en,
    output swap_h, swap_v, color_valid, rgb0, rgb1, rgb2, rgb3, palette_idx, busy
  );

  modport slave (
    output btn_h, btn_v, btn_pal, auto_en,
    input  swap_h, swap_v, color_valid, rgb0, rgb1, rgb2, rgb3, palette_idx, busy
  );
endinterface

// File: rtl/color_sequencer.sv
// ---------------------------------------------------------------------------
// color_sequencer
// Conditions three pushbuttons and an auto-demo timer into sticky requests,
// arbitrates them (PAL > H > V) and drives non-overlapping swap strobes and
// palette loads towards the four-quadrant colour processor.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : color_sequencer_if.master (buttons/auto_en in, strobes/palette out)
// ---------------------------------------------------------------------------
module color_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned AUTO_PERIOD     = 25000000,
  parameter int unsigned PULSE_LEN       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  color_sequencer_if.master     bus
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned AP_W = $clog2(AUTO_PERIOD);
  localparam int unsigned PL_W = $clog2(PULSE_LEN + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ZERO = DB_W'(1'b0);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1'b1);
  localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_PERIOD - 1);
  localparam logic [AP_W-1:0] AP_ZERO = AP_W'(1'b0);
  localparam logic [AP_W-1:0] AP_ONE  = AP_W'(1'b1);
  localparam logic [PL_W-1:0] PL_LAST = PL_W'(PULSE_LEN - 1);
  localparam logic [PL_W-1:0] PL_ZERO = PL_W'(1'b0);
  localparam logic [PL_W-1:0] PL_ONE  = PL_W'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PULSE_H = 3'd1,
    ST_PULSE_V = 3'd2,
    ST_LOAD1   = 3'd3,
    ST_LOAD2   = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  // Palette table, packed as {rgb0, rgb1, rgb2, rgb3}.
  function automatic logic [95:0] palette_f(input logic [1:0] idx);
    logic [95:0] val;
    case (idx)
      2'd0:    val = {24'hff0000, 24'h00ff00, 24'h0000ff, 24'hffff00};
      2'd1:    val = {24'hffffff, 24'h000000, 24'hff00ff, 24'h00ffff};
      2'd2:    val = {24'hff8000, 24'h0080ff, 24'h80ff00, 24'h808080};
      2'd3:    val = {24'h400040, 24'h004040, 24'hc0c0c0, 24'hff0080};
      default: val = {24'hff0000, 24'h00ff00, 24'h0000ff, 24'hffff00};
    endcase
    return val;
  endfunction

  // Request bit order everywhere: [0]=H, [1]=V, [2]=PAL.
  logic [2:0]      raw_s;
  logic [2:0]      sync1_r;
  logic [2:0]      sync2_r;
  logic [2:0]      deb_r;
  logic [2:0]      deb_d_r;
  logic [DB_W-1:0] db_cnt_r [3];
  logic [AP_W-1:0] timer_r;
  logic [1:0]      step_r;
  logic            tick_s;
  logic [2:0]      tick_set_s;
  logic [2:0]      set_s;
  logic [2:0]      clr_s;
  logic [2:0]      pend_r;
  state_t          state_r;
  state_t          state_nxt;
  logic [PL_W-1:0] cnt_r;
  logic [PL_W-1:0] cnt_nxt;
  logic            pal_step_s;
  logic [1:0]      next_idx_s;
  logic            swap_h_r;
  logic            swap_v_r;
  logic            color_valid_r;
  logic            busy_r;
  logic [1:0]      palette_idx_r;
  logic [95:0]     rgb_r;

  assign raw_s      = {bus.btn_pal, bus.btn_v, bus.btn_h};
  assign tick_s     = bus.auto_en && (timer_r == AP_LAST);
  assign next_idx_s = palette_idx_r + 2'd1;
  // Only debounced rising edges create requests; release is ignored.
  assign set_s      = (deb_r & ~deb_d_r) | tick_set_s;

  // Two-flop synchronisers and per-button debounce counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      deb_r   <= 3'b000;
      deb_d_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        db_cnt_r[i] <= DB_ZERO;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          db_cnt_r[i] <= DB_ZERO;
        end else if (db_cnt_r[i] == DB_LAST) begin
          deb_r[i]    <= sync2_r[i];
          db_cnt_r[i] <= DB_ZERO;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
        end
      end
    end
  end

  // Auto-demo timer and H -> V -> PAL step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r <= AP_ZERO;
      step_r  <= 2'd0;
    end else if (!bus.auto_en) begin
      timer_r <= AP_ZERO;
    end else if (tick_s) begin
      timer_r <= AP_ZERO;
      step_r  <= (step_r >= 2'd2) ? 2'd0 : step_r + 2'd1;
    end else begin
      timer_r <= timer_r + AP_ONE;
    end
  end

  // Decode the current auto step into a request bit.
  always_comb begin
    tick_set_s = 3'b000;
    if (tick_s) begin
      case (step_r)
        2'd0:    tick_set_s = 3'b001;
        2'd1:    tick_set_s = 3'b010;
        2'd2:    tick_set_s = 3'b100;
        default: tick_set_s = 3'b001;
      endcase
    end else begin
      tick_set_s = 3'b000;
    end
  end

  // Sticky pending flags; a new event on the accept edge keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= 3'b000;
    end else begin
      pend_r <= (pend_r & ~clr_s) | set_s;
    end
  end

  // FSM next-state, arbitration and pulse timing.
  always_comb begin
    state_nxt  = state_r;
    cnt_nxt    = cnt_r;
    clr_s      = 3'b000;
    pal_step_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt = PL_ZERO;
        if (pend_r[2]) begin
          state_nxt  = ST_LOAD1;
          clr_s      = 3'b100;
          pal_step_s = 1'b1;
        end else if (pend_r[0]) begin
          state_nxt = ST_PULSE_H;
          clr_s     = 3'b001;
        end else if (pend_r[1]) begin
          state_nxt = ST_PULSE_V;
          clr_s     = 3'b010;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_PULSE_H, ST_PULSE_V, ST_GAP: begin
        if (cnt_r == PL_LAST) begin
          state_nxt = (state_r == ST_GAP) ? ST_IDLE : ST_GAP;
          cnt_nxt   = PL_ZERO;
        end else begin
          cnt_nxt = cnt_r + PL_ONE;
        end
      end
      ST_LOAD1: begin
        state_nxt = ST_LOAD2;
      end
      ST_LOAD2: begin
        state_nxt = ST_GAP;
        cnt_nxt   = PL_ZERO;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = PL_ZERO;
      end
    endcase
  end

  // State register; strobes are decoded from the next state so they are
  // registered and line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= PL_ZERO;
      busy_r        <= 1'b0;
      swap_h_r      <= 1'b0;
      swap_v_r      <= 1'b0;
      color_valid_r <= 1'b0;
      palette_idx_r <= 2'd0;
      rgb_r         <= palette_f(2'd0);
    end else begin
      state_r       <= state_nxt;
      cnt_r         <= cnt_nxt;
      busy_r        <= (state_nxt != ST_IDLE);
      swap_h_r      <= (state_nxt == ST_PULSE_H);
      swap_v_r      <= (state_nxt == ST_PULSE_V);
      color_valid_r <= (state_nxt == ST_LOAD2);
      // New palette becomes visible in LOAD cycle 1, one cycle ahead of
      // color_valid so the colours are stable when the strobe is seen.
      if (pal_step_s) begin
        palette_idx_r <= next_idx_s;
        rgb_r         <= palette_f(next_idx_s);
      end else begin
        palette_idx_r <= palette_idx_r;
        rgb_r         <= rgb_r;
      end
    end
  end

  assign bus.swap_h      = swap_h_r;
  assign bus.swap_v      = swap_v_r;
  assign bus.color_valid = color_valid_r;
  assign bus.busy        = busy_r;
  assign bus.palette_idx = palette_idx_r;
  assign bus.rgb0        = rgb_r[95:72];
  assign bus.rgb1        = rgb_r[71:48];
  assign bus.rgb2        = rgb_r[47:24];
  assign bus.rgb3        = rgb_r[23:0];

endmodule

// File: tb/tb_color_sequencer.sv
// ---------------------------------------------------------------------------
// tb_color_sequencer
// Directed bench for color_sequencer with DEBOUNCE_CYCLES=4, AUTO_PERIOD=20,
// PULSE_LEN=2. Inputs change and outputs are sampled on the falling edge.
// A small recorder logs every strobe burst (kind, start, end) so order,
// length and spacing of pulses can be compared with hand-derived values.
// ---------------------------------------------------------------------------
module tb_color_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  color_sequencer_if bus ();

  color_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .AUTO_PERIOD     (20),
    .PULSE_LEN       (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks_n = 0;
  int errors_n = 0;

  // Strobe recorder: kind = {color_valid, swap_v, swap_h}.
  logic [2:0] mon_k_s;
  logic [2:0] prev_k_r = 3'b000;
  int         cyc_n_r = 0;
  int         overlap_n_r = 0;
  logic [2:0] ev_kind [$];
  int         ev_rise [$];
  int         ev_fall [$];

  assign mon_k_s = {bus.color_valid, bus.swap_v, bus.swap_h};

  // Log strobe bursts and count cycles with more than one strobe high.
  always @(negedge clk) begin
    if (mon_k_s != 3'b000 && mon_k_s != 3'b001 && mon_k_s != 3'b010 && mon_k_s != 3'b100)
      overlap_n_r <= overlap_n_r + 1;
    if (prev_k_r == 3'b000 && mon_k_s != 3'b000) begin
      ev_kind.push_back(mon_k_s);
      ev_rise.push_back(cyc_n_r);
    end
    if (prev_k_r != 3'b000 && mon_k_s == 3'b000)
      ev_fall.push_back(cyc_n_r);
    prev_k_r <= mon_k_s;
    cyc_n_r  <= cyc_n_r + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input logic [2:0] b);
    bus.btn_h   = b[0];
    bus.btn_v   = b[1];
    bus.btn_pal = b[2];
  endtask

  // kinds holds expected burst kinds, first burst in bits [2:0].
  task automatic check_events(input string tag, input int base, input int n, input logic [8:0] kinds);
    logic [2:0] ek;
    check($sformatf("%s_count", tag), ev_kind.size() - base, n);
    check($sformatf("%s_falls", tag), ev_fall.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < ev_kind.size() && base + i < ev_fall.size()) begin
        ek = kinds[3*i +: 3];
        check($sformatf("%s_kind%0d", tag, i), ev_kind[base+i], ek);
        check($sformatf("%s_len%0d", tag, i), ev_fall[base+i] - ev_rise[base+i],
              (ek == 3'b100) ? 32'd1 : 32'd2);
        if (i > 0)
          check($sformatf("%s_gap%0d", tag, i),
                (ev_rise[base+i] - ev_fall[base+i-1]) >= 2, 32'd1);
      end
    end
  endtask

  // One palette press: LOAD1 at cycle 8, color_valid at cycle 9 only.
  task automatic pal_press(input string tag, input logic [1:0] idx,
                           input logic [23:0] c0, input logic [23:0] c1, input logic [23:0] c3);
    int base;
    base = ev_kind.size();
    set_btn(3'b100);
    tick(8);
    check($sformatf("%s_idx", tag), bus.palette_idx, idx);
    check($sformatf("%s_rgb0", tag), bus.rgb0, c0);
    check($sformatf("%s_rgb1", tag), bus.rgb1, c1);
    check($sformatf("%s_rgb3", tag), bus.rgb3, c3);
    check($sformatf("%s_cv_c8", tag), bus.color_valid, 1'b0);
    tick(1);
    check($sformatf("%s_cv_c9", tag), bus.color_valid, 1'b1);
    check($sformatf("%s_rgb0_c9", tag), bus.rgb0, c0);
    tick(1);
    check($sformatf("%s_cv_c10", tag), bus.color_valid, 1'b0);
    set_btn(3'b000);
    tick(15);
    check_events(tag, base, 1, 9'b000_000_100);
  endtask

  initial begin
    int base;
    set_btn(3'b000);
    bus.auto_en = 1'b0;
    rst = 1'b1;
    tick(3);

    // 1. reset values, press held under reset
    check("rst_swap_h", bus.swap_h, 1'b0);
    check("rst_swap_v", bus.swap_v, 1'b0);
    check("rst_cv", bus.color_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_idx", bus.palette_idx, 2'd0);
    check("rst_rgb0", bus.rgb0, 24'hff0000);
    check("rst_rgb1", bus.rgb1, 24'h00ff00);
    check("rst_rgb2", bus.rgb2, 24'h0000ff);
    check("rst_rgb3", bus.rgb3, 24'hffff00);
    base = ev_kind.size();
    set_btn(3'b001);
    tick(12);
    set_btn(3'b000);
    tick(3);
    rst = 1'b0;
    tick(20);
    check("rst_hold_events", ev_kind.size() - base, 0);
    check("rst_hold_busy", bus.busy, 1'b0);

    // 2. clean btn_h press: swap_h high in cycles 8..9, busy low from 12
    base = ev_kind.size();
    set_btn(3'b001);
    tick(7);
    check("h_c7_swap", bus.swap_h, 1'b0);
    check("h_c7_busy", bus.busy, 1'b0);
    tick(1);
    check("h_c8_swap", bus.swap_h, 1'b1);
    check("h_c8_busy", bus.busy, 1'b1);
    tick(1);
    check("h_c9_swap", bus.swap_h, 1'b1);
    tick(1);
    check("h_c10_swap", bus.swap_h, 1'b0);
    check("h_c10_busy", bus.busy, 1'b1);
    set_btn(3'b000);
    tick(1);
    check("h_c11_busy", bus.busy, 1'b1);
    tick(1);
    check("h_c12_busy", bus.busy, 1'b0);
    tick(15);
    check_events("h_press", base, 1, 9'b000_000_001);

    // glitch shorter than the debounce window
    base = ev_kind.size();
    set_btn(3'b001);
    tick(3);
    set_btn(3'b000);
    tick(20);
    check("h_glitch_events", ev_kind.size() - base, 0);
    check("h_glitch_busy", bus.busy, 1'b0);

    // 3. four palette presses, wrapping back to palette 0
    pal_press("pal1", 2'd1, 24'hffffff, 24'h000000, 24'h00ffff);
    pal_press("pal2", 2'd2, 24'hff8000, 24'h0080ff, 24'h808080);
    pal_press("pal3", 2'd3, 24'h400040, 24'h004040, 24'hff0080);
    pal_press("pal0", 2'd0, 24'hff0000, 24'h00ff00, 24'hffff00);

    // 4. simultaneous presses: LOAD, then H at cycle 13, then V at cycle 18
    base = ev_kind.size();
    set_btn(3'b111);
    tick(8);
    check("all3_idx", bus.palette_idx, 2'd1);
    tick(5);
    check("all3_h_c13", bus.swap_h, 1'b1);
    tick(5);
    check("all3_v_c18", bus.swap_v, 1'b1);
    set_btn(3'b000);
    tick(15);
    check_events("all3", base, 3, 9'b010_001_100);

    // 5. auto demo: ticks at edges 20, 40, 60 -> H, V, PAL
    base = ev_kind.size();
    bus.auto_en = 1'b1;
    tick(20);
    check("auto_c20_swap_h", bus.swap_h, 1'b0);
    tick(1);
    check("auto_c21_swap_h", bus.swap_h, 1'b1);
    tick(49);
    bus.auto_en = 1'b0;
    check_events("auto", base, 3, 9'b100_010_001);
    check("auto_idx", bus.palette_idx, 2'd2);
    check("auto_rgb0", bus.rgb0, 24'hff8000);

    // drop auto_en mid-count; re-raise must restart the full period
    bus.auto_en = 1'b1;
    tick(5);
    bus.auto_en = 1'b0;
    tick(3);
    base = ev_kind.size();
    bus.auto_en = 1'b1;
    tick(20);
    check("rearm_early_events", ev_kind.size() - base, 0);
    check("rearm_c20_swap_h", bus.swap_h, 1'b0);
    tick(1);
    check("rearm_c21_swap_h", bus.swap_h, 1'b1);
    bus.auto_en = 1'b0;
    tick(10);
    check_events("rearm", base, 1, 9'b000_000_001);

    // 6. reset during the first swap_v cycle, with H pending behind it
    base = ev_kind.size();
    set_btn(3'b010);
    tick(1);
    set_btn(3'b011);
    tick(7);
    check("rstv_c8_swap_v", bus.swap_v, 1'b1);
    rst = 1'b1;
    set_btn(3'b000);
    tick(1);
    check("rstv_swap_v", bus.swap_v, 1'b0);
    check("rstv_swap_h", bus.swap_h, 1'b0);
    check("rstv_busy", bus.busy, 1'b0);
    check("rstv_idx", bus.palette_idx, 2'd0);
    check("rstv_rgb0", bus.rgb0, 24'hff0000);
    tick(1);
    rst = 1'b0;
    tick(30);
    check("rstv_events", ev_kind.size() - base, 1);
    if (ev_kind.size() > base && ev_fall.size() > base) begin
      check("rstv_kind", ev_kind[base], 3'b010);
      check("rstv_len", ev_fall[base] - ev_rise[base], 32'd1);
    end
    check("rstv_busy_after", bus.busy, 1'b0);

    check("no_overlap", overlap_n_r, 0);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule

// File: doc/color_sequencer.md
Name: color_sequencer

Overview:
Control-side sequencer for the four-quadrant colour processor. Conditions three pushbuttons (swap horizontal, swap vertical, next palette) and an auto-demo timer into requests. Arbitrates among the requests and drives the processor's swap_h / swap_v / color_valid / rgb0..rgb3 inputs with correctly shaped, non-overlapping pulses. Sits between board I/O and the colour processor; SW0/SW1 bypass this block.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable synchronised samples required to accept a button level change (≥2)
AUTO_PERIOD, 25000000, clk cycles between auto-demo ticks (≥4)
PULSE_LEN, 4, cycles a swap strobe is held high; also the length of the post-operation low gap (≥1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
btn_h  in  1  raw async button, request horizontal swap
btn_v  in  1  raw async button, request vertical swap
btn_pal  in  1  raw async button, request next palette
auto_en  in  1  synchronous level, enables the auto-demo timer
swap_h  out  1  registered swap strobe to processor
swap_v  out  1  registered swap strobe to processor
color_valid  out  1  registered one-cycle palette load strobe
rgb0..rgb3  out  24 each  registered palette colours
palette_idx  out  2  currently selected palette
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (clk edge with rst=1): FSM=IDLE; swap_h=swap_v=color_valid=busy=0; palette_idx=0; rgb0..3=palette 0; pending flags, timer, auto step, debounce counters, debounced levels and synchronisers all 0. rst mid-operation aborts any pulse immediately; outputs take reset values on that edge.
- Input conditioning per button: 2-FF synchroniser, then debounce. The debounced level flips only after the synchronised sample differs from it for DEBOUNCE_CYCLES consecutive cycles. The counter clears whenever the sample equals the debounced level. A debounced 0→1 edge sets the matching pending flag on the next edge. Falling edges are ignored.
- Auto timer: while auto_en=1, counts 0..AUTO_PERIOD-1 and wraps. At the wrap it emits a one-cycle tick that sets one pending flag, selected by a 2-bit step in the order H, V, PAL. The step then advances (0→1→2→0). auto_en=0 clears the timer to 0 on that edge. The step and any pending flags are held.
- Pending flags are sticky. A second request while a flag is already set merges; no counting. Button and tick setting flags in the same cycle are OR'ed. A flag cleared on the edge FSM accepts it, while the same flag is set again by a new event, ends set (set wins).
- Arbitration in IDLE, fixed priority: PAL > H > V. Exactly one request is accepted per pass. The accepted flag is cleared on the transition edge.
- FSM:
  - IDLE: no pending → stay. Otherwise go to PULSE_H, PULSE_V or LOAD.
  - PULSE_H: swap_h=1 for exactly PULSE_LEN cycles. The first high cycle is the cycle after the pending flag was first visible in IDLE. Then go to GAP.
  - PULSE_V: same as PULSE_H, using swap_v.
  - LOAD: two cycles. Cycle 1: palette_idx ← (palette_idx+1) mod 4 and rgb0..3 ← new palette (registered). Cycle 2: color_valid=1 with rgb stable. Then go to GAP.
  - GAP: all strobes 0 for PULSE_LEN cycles, then IDLE. This guarantees the processor sees every swap strobe deasserted before the next one.
- swap_h and swap_v are never high simultaneously. color_valid is never high while a swap strobe is high.
- rgb0..3 change only in LOAD cycle 1 or on reset.
- Palettes (rgb0, rgb1, rgb2, rgb3):
  - 0: ff0000, 00ff00, 0000ff, ffff00
  - 1: ffffff, 000000, ff00ff, 00ffff
  - 2: ff8000, 0080ff, 80ff00, 808080
  - 3: 400040, 004040, c0c0c0, ff0080
  - Index 3 wraps to 0.
- busy = (state != IDLE), registered together with the state.

Test Plan:
(Use DEBOUNCE_CYCLES=4, AUTO_PERIOD=20, PULSE_LEN=2.)
1. Reset → all strobes 0, palette_idx=0, rgb0=ff0000, rgb3=ffff00, busy=0. Hold rst=1 across a button press → no strobe.
2. btn_h clean press held 10 cycles → exactly one swap_h pulse of 2 cycles, then ≥2 low cycles, busy returns 0. btn_h glitch high for 3 cycles → no pulse.
3. btn_pal press → palette_idx=1, rgb0=ffffff, rgb1=000000, then color_valid high exactly one cycle. Four presses total → idx wraps to 0 and rgb0=ff0000.
4. btn_h, btn_v, btn_pal debounced edges on the same cycle → order LOAD, swap_h pulse, swap_v pulse, each separated by a 2-cycle gap. Strobes never overlap.
5. auto_en=1 for 70 cycles → ticks at timer wrap produce swap_h, then swap_v, then palette load. Drop auto_en mid-count and re-raise → next tick is a full 20 cycles after re-raise.
6. Assert rst during PULSE_V's first high cycle → swap_v=0 on that edge, pending cleared. After release, no residual pulse.
